baudrate_generator: RTL and testbench
=====================================

Name: baudrate_generator

Overview:
- SPI master serial-clock generator, driven from the APB clock, inside the APB-interfaced SPI master core.
- Computes the baud-rate divisor from the SPPR/SPR fields and produces SCLK with the configured CPOL idle level while a transfer is enabled.
- Emits one-PCLK pre-edge strobes that the shift-register block uses to time shifting and sampling.

Parameters:
- CNT_W, 12, width of the divisor output and the half-period counter; must be ≥12 to hold the maximum divisor of 2048.

Ports:
- PCLK input 1 system clock; all state updates on the rising edge.
- PRESETn input 1 asynchronous reset, active-high (1 = reset, despite the legacy name).
- spi_mode input 2 00 = run, 01 = wait, 10 = stop, 11 = reserved.
- spiswai input 1 1 = stop SCLK while in wait mode.
- sppr input 3 baud prescaler selection.
- spr input 3 baud rate selection.
- cpol input 1 clock polarity (SCLK idle level).
- cpha input 1 clock phase; 0 = sample on leading edge, 1 = sample on trailing edge.
- ss input 1 slave select, active-low; 0 = transfer enabled.
- sclk output 1 serial clock.
- flag_low output 1 pulse in the cycle before an SCLK rising edge.
- flag_high output 1 pulse in the cycle before an SCLK falling edge.
- flags_low output 1 flag_low, qualified: the rising edge is the sample edge.
- flags_high output 1 flag_high, qualified: the falling edge is the sample edge.
- baudratedivisor output CNT_W (sppr+1) * 2^(spr+1).

Behaviour:
- baudratedivisor is combinational and always valid, including during reset.
  - Range: 2 (sppr=0, spr=0) to 2048 (sppr=7, spr=7).
- half = baudratedivisor >> 1; its minimum value is 1.
- enable = ~ss AND (spi_mode==00 OR (spi_mode==01 AND ~spiswai)). Modes 10 and 11 are disabled.
- Reset, asynchronous: count=0, sclk=0.
  - All flags are 0 during reset because they are gated by enable and the counter state.
- When disabled, on every PCLK: count←0 and sclk←cpol.
- When enabled, on every PCLK:
  - If count ≥ half-1: count←0 and sclk←~sclk.
  - Otherwise: count←count+1.
  - The ≥ comparison guarantees recovery if sppr/spr shrink mid-transfer.
- The SCLK period is baudratedivisor PCLK cycles, with 50% duty.
- The first SCLK edge occurs half PCLKs after enable rises, given sclk was already at cpol.
- Pre-edge cycle: enable AND count ≥ half-1.
  - Combinational outputs:
    - flag_low = preedge AND sclk==0.
    - flag_high = preedge AND sclk==1.
    - flags_low = flag_low AND (cpol^cpha)==0.
    - flags_high = flag_high AND (cpol^cpha)==1.
  - Each strobe is high for exactly one PCLK per SCLK edge.
- Deasserting ss or entering stop mid-transfer:
  - All flags go 0 immediately.
  - sclk returns to cpol on the next PCLK.
  - The counter restarts from 0 on re-enable.
- A cpol change while disabled is reflected on sclk on the next PCLK.
- A cpol or cpha change while enabled is not guarded; software must change them only with ss=1.

Optional Feature:
- Macro BAUD_DIV_LATCH_EN.
- Defined:
  - sppr and spr are captured into internal registers on the PCLK where enable rises, and on reset (captured value 0).
  - baudratedivisor and half are derived from the latched values, so reconfiguration mid-transfer has no effect until the next enable.
- Undefined: divisor is purely combinational from the live inputs, as above.

Decomposition:
- Shared package spi_pkg holds:
  - Mode constants SPI_RUN=2'b00, SPI_WAIT=2'b01, SPI_STOP=2'b10.
  - CNT_W.
  - A function calc_baud_div(sppr, spr) returning the CNT_W-bit divisor.
- No sub-module is needed; the block is a single module.

Test Plan:
- Reset:
  - Stimulus: PRESETn=1 with sppr=0, spr=0.
  - Required: sclk=0, all flags 0, baudratedivisor=2.
  - Stimulus: release reset with ss=1, cpol=0.
  - Required: sclk stays 0.
- Mode 1, fastest clock:
  - Stimulus: sppr=0, spr=0, cpol=0, cpha=1, spi_mode=01, spiswai=0; ss 1→0.
  - Required: sclk toggles every PCLK (period 20 ns at 100 MHz).
  - Required: flag_low/flag_high alternate each cycle.
  - Required: flags_high pulses before each falling edge and flags_low stays 0.
- Divisor arithmetic:
  - Stimulus: sppr=2, spr=1.
  - Required: baudratedivisor=12 and sclk high/low phases of 6 PCLK each.
  - Stimulus: sppr=7, spr=7.
  - Required: baudratedivisor=2048.
- Mode 0 vs mode 3:
  - Stimulus: cpol=0, cpha=0.
  - Required: flags_low pulses before rising edges only.
  - Stimulus: cpol=1, cpha=1, ss=1.
  - Required: sclk idles 1; after enable the first edge is falling and flags_low marks the rising edges.
- Wait/stop gating:
  - Stimulus: spi_mode=01 with spiswai=1, or spi_mode=10, mid-transfer.
  - Required: flags drop immediately and sclk returns to cpol the next PCLK.
  - Stimulus: restore spi_mode=00.
  - Required: the first edge occurs half PCLKs later.
- Async reset mid-transfer:
  - Stimulus: assert PRESETn between PCLK edges.
  - Required: sclk=0 and flags 0 immediately, without waiting for a PCLK edge.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master core: SPI mode encodings, the
// divisor width, and the baud-rate divisor calculation.
package spi_pkg;

    localparam int CNT_W = 12;

    localparam logic [1:0] SPI_RUN  = 2'b00;
    localparam logic [1:0] SPI_WAIT = 2'b01;
    localparam logic [1:0] SPI_STOP = 2'b10;

    // Returns (sppr + 1) * 2^(spr + 1).
    // The doubling is a separate shift because spr + 1 wraps to 0 in
    // 3 bits when spr = 7, which would give the wrong shift amount.
    function automatic logic [CNT_W-1:0] calc_baud_div(input logic [2:0] sppr,
                                                       input logic [2:0] spr);
        logic [CNT_W-1:0] pre;
        pre = CNT_W'(sppr) + CNT_W'(1);
        return (pre << 1) << spr;
    endfunction

endpackage

// File: rtl/baudrate_generator.sv
// SPI master serial-clock generator running on PCLK.
// Produces SCLK at PCLK / baudratedivisor, idling at cpol while disabled,
// and one-PCLK strobes in the cycle before each SCLK edge.
// Optional build macro BAUD_DIV_LATCH_EN: freezes sppr/spr at the start of
// each enabled period so mid-transfer reconfiguration only takes effect on
// the next enable.
module baudrate_generator #(
    parameter int CNT_W = spi_pkg::CNT_W
) (
    input  logic             PCLK,
    input  logic             PRESETn,    // active-high async reset despite the name
    input  logic [1:0]       spi_mode,
    input  logic             spiswai,
    input  logic [2:0]       sppr,
    input  logic [2:0]       spr,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             ss,
    output logic             sclk,
    output logic             flag_low,
    output logic             flag_high,
    output logic             flags_low,
    output logic             flags_high,
    output logic [CNT_W-1:0] baudratedivisor
);
    import spi_pkg::*;

    logic             enable;
    logic             preedge;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] half_m1;
    logic [2:0]       sppr_eff;
    logic [2:0]       spr_eff;

    assign enable = ~ss && ((spi_mode == SPI_RUN) ||
                            ((spi_mode == SPI_WAIT) && ~spiswai));

`ifdef BAUD_DIV_LATCH_EN
    logic [2:0] sppr_q;
    logic [2:0] spr_q;
    logic       enable_q;
    logic       enable_rise;

    assign enable_rise = enable && !enable_q;

    // Capture the divisor selection on the first enabled cycle.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            sppr_q   <= 3'd0;
            spr_q    <= 3'd0;
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
            if (enable_rise) begin
                sppr_q <= sppr;
                spr_q  <= spr;
            end
        end
    end

    // During the capture cycle the registers still hold the previous
    // selection, so the live value is used for that one cycle.
    assign sppr_eff = enable_rise ? sppr : sppr_q;
    assign spr_eff  = enable_rise ? spr  : spr_q;
`else
    assign sppr_eff = sppr;
    assign spr_eff  = spr;
`endif

    assign baudratedivisor = CNT_W'(calc_baud_div(sppr_eff, spr_eff));
    assign half            = baudratedivisor >> 1;
    assign half_m1         = half - CNT_W'(1);

    // Flags are masked during reset: with the fastest divisor half-1 is 0,
    // so count = 0 alone would otherwise look like a pre-edge cycle.
    assign preedge    = enable && !PRESETn && (count >= half_m1);
    assign flag_low   = preedge && !sclk;
    assign flag_high  = preedge && sclk;
    assign flags_low  = flag_low  && ((cpol ^ cpha) == 1'b0);
    assign flags_high = flag_high && ((cpol ^ cpha) == 1'b1);

    // Half-period counter and SCLK toggle; >= lets a shrinking divisor
    // recover immediately instead of wrapping the counter.
    always_ff @(posedge PCLK or posedge PRESETn) begin
        if (PRESETn) begin
            count <= '0;
            sclk  <= 1'b0;
        end else if (!enable) begin
            count <= '0;
            sclk  <= cpol;
        end else if (count >= half_m1) begin
            count <= '0;
            sclk  <= ~sclk;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_baudrate_generator.sv
// Testbench for baudrate_generator: directed scenarios plus randomized
// segments, checked by a scoreboard fed from a timing-level reference model.
module tb_baudrate_generator;

    logic        PCLK;
    logic        PRESETn;
    logic [1:0]  spi_mode;
    logic        spiswai;
    logic [2:0]  sppr;
    logic [2:0]  spr;
    logic        cpol;
    logic        cpha;
    logic        ss;
    logic        sclk;
    logic        flag_low;
    logic        flag_high;
    logic        flags_low;
    logic        flags_high;
    logic [11:0] baudratedivisor;

    baudrate_generator #(.CNT_W(12)) dut (
        .PCLK            (PCLK),
        .PRESETn         (PRESETn),
        .spi_mode        (spi_mode),
        .spiswai         (spiswai),
        .sppr            (sppr),
        .spr             (spr),
        .cpol            (cpol),
        .cpha            (cpha),
        .ss              (ss),
        .sclk            (sclk),
        .flag_low        (flag_low),
        .flag_high       (flag_high),
        .flags_low       (flags_low),
        .flags_high      (flags_high),
        .baudratedivisor (baudratedivisor)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        sclk;
        logic [3:0]  flags;
        logic [11:0] div;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state: consecutive enabled edges and expected SCLK.
    int   m_n    = 0;
    bit   m_sclk = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int pp, input int rr);
        return (pp + 1) * (1 << (rr + 1));
    endfunction

    function automatic bit en_of(input bit s, input int mode, input bit swai);
        return !s && (mode == 0 || (mode == 1 && !swai));
    endfunction

    // One PCLK cycle: account for the edge just taken using the inputs that
    // were applied before it, apply new inputs, then push the expectation
    // for the sample taken at the following falling edge.
    task automatic step(input bit rst_i, input bit ss_i, input logic [1:0] mode_i,
                        input bit swai_i, input logic [2:0] pp, input logic [2:0] rr,
                        input bit pol, input bit pha);
        exp_t e;
        int   h;
        bit   pre;
        bit   fl;
        bit   fh;
        @(posedge PCLK);
        #1;
        h = div_of(int'(sppr), int'(spr)) / 2;
        if (PRESETn) begin
            m_sclk = 1'b0;
            m_n    = 0;
        end else if (en_of(ss, int'(spi_mode), spiswai)) begin
            m_n++;
            m_sclk = cpol ^ (((m_n / h) % 2) == 1);
        end else begin
            m_n    = 0;
            m_sclk = cpol;
        end
        PRESETn  = rst_i;
        ss       = ss_i;
        spi_mode = mode_i;
        spiswai  = swai_i;
        sppr     = pp;
        spr      = rr;
        cpol     = pol;
        cpha     = pha;
        if (PRESETn) begin
            m_sclk = 1'b0;
            m_n    = 0;
        end
        h   = div_of(int'(sppr), int'(spr)) / 2;
        pre = !PRESETn && en_of(ss, int'(spi_mode), spiswai) && ((m_n % h) == h - 1);
        fl  = pre && !m_sclk;
        fh  = pre && m_sclk;
        e.sclk  = m_sclk;
        e.flags = {fl, fh, fl && (cpol == cpha), fh && (cpol != cpha)};
        e.div   = 12'(div_of(int'(sppr), int'(spr)));
        q.push_back(e);
    endtask

    // Convenience: keep the current configuration, change only gating.
    task automatic cyc(input bit ss_i, input logic [1:0] mode_i, input bit swai_i);
        step(1'b0, ss_i, mode_i, swai_i, sppr, spr, cpol, cpha);
    endtask

    // Convenience: change configuration in a disabled cycle.
    task automatic cfg(input logic [2:0] pp, input logic [2:0] rr, input bit pol, input bit pha);
        step(1'b0, 1'b1, 2'b00, 1'b0, pp, rr, pol, pha);
    endtask

    // Scoreboard monitor.
    always @(negedge PCLK) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sclk", int'(sclk), int'(e.sclk));
            chk("flags{fl,fh,fsl,fsh}", int'({flag_low, flag_high, flags_low, flags_high}),
                int'(e.flags));
            chk("baudratedivisor", int'(baudratedivisor), int'(e.div));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        PRESETn  = 1'b1;
        ss       = 1'b1;
        spi_mode = 2'b00;
        spiswai  = 1'b0;
        sppr     = 3'd0;
        spr      = 3'd0;
        cpol     = 1'b0;
        cpha     = 1'b0;

        #2;
        chk("reset_div", int'(baudratedivisor), 2);
        chk("reset_sclk", int'(sclk), 0);
        chk("reset_flags", int'({flag_low, flag_high, flags_low, flags_high}), 0);
        repeat (3) step(1'b1, 1'b1, 2'b00, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);

        // Wait mode, fastest clock, cpha=1
        step(1'b0, 1'b1, 2'b01, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1);
        repeat (10) cyc(1'b0, 2'b01, 1'b0);

        // Divisor 12, mode 0
        cfg(3'd2, 3'd1, 1'b0, 1'b0);
        #1;
        chk("div_12", int'(baudratedivisor), 12);
        repeat (30) cyc(1'b0, 2'b00, 1'b0);

        // Divisor 2048, mode 3
        cfg(3'd7, 3'd7, 1'b1, 1'b1);
        #1;
        chk("div_2048", int'(baudratedivisor), 2048);
        repeat (1030) cyc(1'b0, 2'b00, 1'b0);

        // Wait/stop gating mid-transfer
        cfg(3'd0, 3'd2, 1'b0, 1'b1);
        repeat (10) cyc(1'b0, 2'b00, 1'b0);
        repeat (3)  cyc(1'b0, 2'b01, 1'b1);
        repeat (10) cyc(1'b0, 2'b00, 1'b0);
        repeat (2)  cyc(1'b0, 2'b10, 1'b0);
        repeat (12) cyc(1'b0, 2'b00, 1'b0);
        cyc(1'b0, 2'b11, 1'b0);
        repeat (5)  cyc(1'b0, 2'b00, 1'b0);

        // Async reset between edges while sclk is high
        cfg(3'd1, 3'd1, 1'b0, 1'b0);
        guard = 0;
        do begin
            cyc(1'b0, 2'b00, 1'b0);
            guard++;
        end while (!(m_sclk && ((m_n + 1) % 4 != 0)) && guard < 20);
        chk("async_setup_sclk_high", int'(m_sclk), 1);
        step(1'b1, 1'b0, 2'b00, 1'b0, sppr, spr, cpol, cpha);
        #1;
        chk("async_sclk", int'(sclk), 0);
        chk("async_flags", int'({flag_low, flag_high, flags_low, flags_high}), 0);
        step(1'b1, 1'b0, 2'b00, 1'b0, sppr, spr, cpol, cpha);
        step(1'b0, 1'b1, 2'b00, 1'b0, sppr, spr, cpol, cpha);

        // Randomized segments
        for (int s = 0; s < 150; s++) begin
            int   len;
            int   h;
            logic [2:0] pp;
            logic [2:0] rr;
            pp  = 3'($urandom_range(0, 7));
            rr  = 3'(($urandom_range(0, 9) == 0) ? $urandom_range(4, 5) : $urandom_range(0, 3));
            cfg(pp, rr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int d = 0; d < int'($urandom_range(0, 2)); d++) begin
                case ($urandom_range(0, 3))
                    0:       cyc(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                    1:       cyc(1'b0, 2'b01, 1'b1);
                    2:       cyc(1'b0, 2'b10, 1'($urandom_range(0, 1)));
                    default: cyc(1'b0, 2'b11, 1'($urandom_range(0, 1)));
                endcase
            end
            h   = div_of(int'(pp), int'(rr)) / 2;
            len = int'($urandom_range(1, 4 * h + 2));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 19) == 0)
                    cyc(1'($urandom_range(0, 1)), 2'b10, 1'b0);
                else if ($urandom_range(0, 1) == 0)
                    cyc(1'b0, 2'b00, 1'($urandom_range(0, 1)));
                else
                    cyc(1'b0, 2'b01, 1'b0);
            end
        end

        @(negedge PCLK);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
